// File: rtl/vram_frame_scanner.sv
// vram_frame_scanner: turns VGA timing counters into 1-bpp frame BRAM reads,
// colours the returned pixel and advances the animation frame on vsync.
// Both the rgb and the sync outputs trail the input counters by two pixel ticks.
module vram_frame_scanner #(
  parameter int          X_OFFSET    = 64,
  parameter int          Y_OFFSET    = 48,
  parameter int          SCALE_SHIFT = 2,
  parameter int          NUM_FRAMES  = 10,
  parameter int          FRAME_HOLD  = 6,
  parameter logic [11:0] FG_COLOR    = 12'hFFF,
  parameter logic [11:0] INK_COLOR   = 12'h000,
  parameter logic [11:0] BG_COLOR    = 12'h00F
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_pixel_tick,
  input  logic [9:0]            i_h_count,
  input  logic [9:0]            i_v_count,
  input  logic                  i_video_on_in,
  input  logic                  i_hsync_in,
  input  logic                  i_vsync_in,
  input  logic                  i_anim_enable,
  input  logic [NUM_FRAMES-1:0] i_pixel_vals,
  output logic [13:0]           o_address,
  output logic                  o_read_enable,
  output logic [3:0]            o_frame_sel,
  output logic [11:0]           o_rgb,
  output logic                  o_hsync_out,
  output logic                  o_vsync_out,
  output logic                  o_video_on_out
);

  localparam int          HOLD_W    = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [10:0] WIN_W     = 11'(128 << SCALE_SHIFT);
  localparam logic [10:0] WIN_H     = 11'(96 << SCALE_SHIFT);
  localparam logic [9:0]  X_OFF     = 10'(X_OFFSET);
  localparam logic [9:0]  Y_OFF     = 10'(Y_OFFSET);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FRAME_HOLD - 1);
  localparam logic [3:0]  FSEL_LAST = 4'(NUM_FRAMES - 1);

  // stage 1 registers
  logic [13:0]       r_address;
  logic              r_read_enable;
  logic              r_s1_win;
  logic              r_s1_von;
  logic              r_s1_hs;
  logic              r_s1_vs;
  // stage 2 registers
  logic [11:0]       r_rgb;
  logic              r_hsync_out;
  logic              r_vsync_out;
  logic              r_video_on_out;
  // animation registers
  logic              r_vs_prev;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [3:0]        r_frame_sel;

  logic [9:0]        w_dx;
  logic [9:0]        w_dy;
  logic [6:0]        w_col;
  logic [6:0]        w_row;
  logic              w_in_win;
  logic [15:0]       w_pix_ext;
  logic              w_pix_sel;
  logic [11:0]       w_rgb_next;
  logic              w_vs_start;
  logic [HOLD_W-1:0] w_hold_next;
  logic [3:0]        w_fsel_next;

  // Window offsets; the >= guard keeps a wrapped subtraction from hitting the window.
  assign w_dx     = i_h_count - X_OFF;
  assign w_dy     = i_v_count - Y_OFF;
  assign w_in_win = i_video_on_in
                  & (i_h_count >= X_OFF) & ({1'b0, w_dx} < WIN_W)
                  & (i_v_count >= Y_OFF) & ({1'b0, w_dy} < WIN_H);
  assign w_col    = 7'(w_dx >> SCALE_SHIFT);
  assign w_row    = 7'(w_dy >> SCALE_SHIFT);

  // Zero-extend the frame bits to 16 so any 4-bit select stays in range.
  always_comb begin
    w_pix_ext                 = 16'h0000;
    w_pix_ext[NUM_FRAMES-1:0] = i_pixel_vals;
  end
  assign w_pix_sel = w_pix_ext[r_frame_sel];

  // Colour selection for the pixel captured one tick earlier.
  always_comb begin
    w_rgb_next = 12'h000;
    if (!r_s1_von) begin
      w_rgb_next = 12'h000;
    end else if (r_s1_win) begin
      w_rgb_next = w_pix_sel ? FG_COLOR : INK_COLOR;
    end else begin
      w_rgb_next = BG_COLOR;
    end
  end

  assign w_vs_start = ~i_vsync_in & r_vs_prev;

  // Hold counter and frame index advance only on vsync starts while animating.
  always_comb begin
    w_hold_next = r_hold_cnt;
    w_fsel_next = r_frame_sel;
    if (w_vs_start && i_anim_enable) begin
      if (r_hold_cnt >= HOLD_LAST) begin
        w_hold_next = {HOLD_W{1'b0}};
        if (r_frame_sel >= FSEL_LAST) begin
          w_fsel_next = 4'd0;
        end else begin
          w_fsel_next = r_frame_sel + 4'd1;
        end
      end else begin
        w_hold_next = r_hold_cnt + HOLD_W'(1);
      end
    end else begin
      w_hold_next = r_hold_cnt;
      w_fsel_next = r_frame_sel;
    end
  end

  // Stage 1: issue the BRAM read and carry the timing flags forward.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_address     <= 14'd0;
      r_read_enable <= 1'b0;
      r_s1_win      <= 1'b0;
      r_s1_von      <= 1'b0;
      r_s1_hs       <= 1'b1;
      r_s1_vs       <= 1'b1;
    end else if (i_pixel_tick) begin
      r_address     <= w_in_win ? {w_row, w_col} : 14'd0;
      r_read_enable <= w_in_win;
      r_s1_win      <= w_in_win;
      r_s1_von      <= i_video_on_in;
      r_s1_hs       <= i_hsync_in;
      r_s1_vs       <= i_vsync_in;
    end
  end

  // Stage 2: register colour and syncs, aligned with the BRAM data.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rgb          <= 12'h000;
      r_hsync_out    <= 1'b1;
      r_vsync_out    <= 1'b1;
      r_video_on_out <= 1'b0;
    end else if (i_pixel_tick) begin
      r_rgb          <= w_rgb_next;
      r_hsync_out    <= r_s1_hs;
      r_vsync_out    <= r_s1_vs;
      r_video_on_out <= r_s1_von;
    end
  end

  // Animation state: vsync edge detector, hold counter and frame index.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_vs_prev   <= 1'b1;
      r_hold_cnt  <= {HOLD_W{1'b0}};
      r_frame_sel <= 4'd0;
    end else if (i_pixel_tick) begin
      r_vs_prev   <= i_vsync_in;
      r_hold_cnt  <= w_hold_next;
      r_frame_sel <= w_fsel_next;
    end
  end

  assign o_address      = r_address;
  assign o_read_enable  = r_read_enable;
  assign o_frame_sel    = r_frame_sel;
  assign o_rgb          = r_rgb;
  assign o_hsync_out    = r_hsync_out;
  assign o_vsync_out    = r_vsync_out;
  assign o_video_on_out = r_video_on_out;

endmodule

// File: tb/tb_vram_frame_scanner.sv
// Testbench for vram_frame_scanner: behavioural frame BRAMs plus a scoreboard
// of expected rgb/sync values, popped as the two-tick pipeline delivers them.
module tb_vram_frame_scanner;

  localparam int NF = 10;
  localparam int FH = 2;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        von;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          pixel_tick;
  logic [9:0]    h_count;
  logic [9:0]    v_count;
  logic          video_on_in;
  logic          hsync_in;
  logic          vsync_in;
  logic          anim_enable;
  logic [NF-1:0] pixel_vals;
  logic [13:0]   address;
  logic          read_enable;
  logic [3:0]    frame_sel;
  logic [11:0]   rgb;
  logic          hsync_out;
  logic          vsync_out;
  logic          video_on_out;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  int   m_fsel;
  int   m_hold;
  logic m_vs_prev;

  always #5 clk = ~clk;

  vram_frame_scanner #(.NUM_FRAMES(NF), .FRAME_HOLD(FH)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_pixel_tick   (pixel_tick),
    .i_h_count      (h_count),
    .i_v_count      (v_count),
    .i_video_on_in  (video_on_in),
    .i_hsync_in     (hsync_in),
    .i_vsync_in     (vsync_in),
    .i_anim_enable  (anim_enable),
    .i_pixel_vals   (pixel_vals),
    .o_address      (address),
    .o_read_enable  (read_enable),
    .o_frame_sel    (frame_sel),
    .o_rgb          (rgb),
    .o_hsync_out    (hsync_out),
    .o_vsync_out    (vsync_out),
    .o_video_on_out (video_on_out)
  );

  // Image content of frame k at address a.
  function automatic logic pix(input int k, input logic [13:0] a);
    logic [13:0] s;
    logic [31:0] kk;
    s  = a >> (k % 7);
    kk = k;
    return s[0] ^ a[7] ^ kk[0];
  endfunction

  // Frame BRAMs: one-clock read latency, output holds while not reading.
  always @(posedge clk) begin
    if (reset) begin
      pixel_vals <= '0;
    end else if (read_enable) begin
      for (int k = 0; k < NF; k++) pixel_vals[k] <= pix(k, address);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reset at an arbitrary point inside a clock period; outputs must clear at once.
  task automatic apply_reset();
    exp_t b;
    @(posedge clk);
    #2;
    reset      = 1'b1;
    pixel_tick = 1'b0;
    #1;
    check_val("rst_address", address, 32'd0);
    check_val("rst_read_enable", read_enable, 32'd0);
    check_val("rst_frame_sel", frame_sel, 32'd0);
    check_val("rst_rgb", rgb, 32'd0);
    check_val("rst_hsync", hsync_out, 32'd1);
    check_val("rst_vsync", vsync_out, 32'd1);
    check_val("rst_video_on", video_on_out, 32'd0);
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    m_fsel    = 0;
    m_hold    = 0;
    m_vs_prev = 1'b1;
    sb_q.delete();
    b.rgb = 12'h000; b.hs = 1'b1; b.vs = 1'b1; b.von = 1'b0;
    sb_q.push_back(b);
  endtask

  // One pixel tick followed by one idle clock (pixel period of 2 clocks).
  task automatic do_tick(input int hh, input int vv, input logic vo,
                         input logic hsi, input logic vsi, input logic an);
    exp_t        e;
    exp_t        got;
    int          dx;
    int          dy;
    logic        inw;
    logic [13:0] ea;
    logic        popped;
    @(negedge clk);
    h_count     = hh[9:0];
    v_count     = vv[9:0];
    video_on_in = vo;
    hsync_in    = hsi;
    vsync_in    = vsi;
    anim_enable = an;
    pixel_tick  = 1'b1;
    dx  = hh - 64;
    dy  = vv - 48;
    inw = vo && dx >= 0 && dx < 512 && dy >= 0 && dy < 384;
    ea  = inw ? 14'((dy / 4) * 128 + dx / 4) : 14'd0;
    if (!vsi && m_vs_prev && an) begin
      if (m_hold == FH - 1) begin
        m_hold = 0;
        m_fsel = (m_fsel == NF - 1) ? 0 : m_fsel + 1;
      end else begin
        m_hold++;
      end
    end
    m_vs_prev = vsi;
    e.rgb = !vo ? 12'h000 : (inw ? (pix(m_fsel, ea) ? 12'hFFF : 12'h000) : 12'h00F);
    e.hs  = hsi;
    e.vs  = vsi;
    e.von = vo;
    sb_q.push_back(e);
    @(negedge clk);
    pixel_tick = 1'b0;
    check_val("address", address, 32'(ea));
    check_val("read_enable", read_enable, 32'(inw));
    check_val("frame_sel", frame_sel, m_fsel);
    popped = 1'b0;
    got    = '0;
    if (sb_q.size() >= 2) begin
      got    = sb_q.pop_front();
      popped = 1'b1;
      check_val("rgb", rgb, 32'(got.rgb));
      check_val("hsync_out", hsync_out, 32'(got.hs));
      check_val("vsync_out", vsync_out, 32'(got.vs));
      check_val("video_on_out", video_on_out, 32'(got.von));
    end
    @(negedge clk);
    if (popped) check_val("rgb_hold", rgb, 32'(got.rgb));
  endtask

  initial begin
    reset       = 1'b1;
    pixel_tick  = 1'b0;
    h_count     = 10'd0;
    v_count     = 10'd0;
    video_on_in = 1'b0;
    hsync_in    = 1'b1;
    vsync_in    = 1'b1;
    anim_enable = 1'b1;
    m_fsel      = 0;
    m_hold      = 0;
    m_vs_prev   = 1'b1;
    apply_reset();

    // Window corners and interior addressing.
    do_tick(64, 48, 1'b1, 1'b1, 1'b1, 1'b1);
    do_tick(87, 57, 1'b1, 1'b1, 1'b1, 1'b1);
    do_tick(575, 431, 1'b1, 1'b1, 1'b1, 1'b1);
    // Just outside each edge, and blanking.
    do_tick(63, 100, 1'b1, 1'b1, 1'b1, 1'b1);
    do_tick(576, 100, 1'b1, 1'b1, 1'b1, 1'b1);
    do_tick(100, 432, 1'b1, 1'b1, 1'b1, 1'b1);
    do_tick(100, 47, 1'b1, 1'b1, 1'b1, 1'b1);
    do_tick(100, 100, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++)
      do_tick($urandom_range(60, 580), $urandom_range(44, 436), 1'b1, 1'b1, 1'b1, 1'b1);
    // Single-tick hsync pulse.
    do_tick(200, 200, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) do_tick(201 + i, 200, 1'b1, 1'b1, 1'b1, 1'b1);

    // Animation: 20 vsync pulses, frame advances every second pulse and wraps.
    for (int p = 0; p < 20; p++) begin
      do_tick(700, 500, 1'b0, 1'b1, 1'b0, 1'b1);
      do_tick(700, 501, 1'b0, 1'b1, 1'b1, 1'b1);
    end
    // Frozen animation.
    for (int p = 0; p < 5; p++) begin
      do_tick(700, 500, 1'b0, 1'b1, 1'b0, 1'b0);
      do_tick(700, 501, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    // Resume and step to frame 7.
    for (int p = 0; p < 14; p++) begin
      do_tick(700, 500, 1'b0, 1'b1, 1'b0, 1'b1);
      do_tick(700, 501, 1'b0, 1'b1, 1'b1, 1'b1);
    end
    for (int i = 0; i < 6; i++)
      do_tick($urandom_range(64, 575), $urandom_range(48, 431), 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of the window.
    do_tick(300, 300, 1'b1, 1'b1, 1'b1, 1'b1);
    apply_reset();
    for (int i = 0; i < 6; i++)
      do_tick(300 + i * 4, 300, 1'b1, 1'b1, 1'b1, 1'b1);
    do_tick(700, 500, 1'b0, 1'b1, 1'b1, 1'b1);
    do_tick(700, 500, 1'b0, 1'b1, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_frame_scanner.md
Name: vram_frame_scanner

Overview:
- Pixel-fetch stage directly upstream of the 1-bpp animation frame BRAMs (FRAME0..FRAME(N-1)), each storing a 128x96 image at 1 bit per address.
- Converts VGA timing counters into a BRAM read address and read enable, and captures the returned pixel bit from the currently selected frame.
- Advances the selected frame every FRAME_HOLD vertical syncs to produce animation.
- Emits 12-bit RGB plus hsync/vsync/video_on, all delayed to stay aligned with the BRAM read latency.

Parameters:
- X_OFFSET, 64: left edge of the image window, in screen pixels.
- Y_OFFSET, 48: top edge of the image window, in screen lines.
- SCALE_SHIFT, 2: the image is scaled by 2^SCALE_SHIFT in both axes, so the default window is 512x384.
- NUM_FRAMES, 10: number of frame BRAMs; frame_sel wraps after NUM_FRAMES-1.
- FRAME_HOLD, 6: number of vsync periods each frame is shown; must be >= 1.
- FG_COLOR, 12'hFFF: RGB driven when the in-window pixel bit is 1.
- INK_COLOR, 12'h000: RGB driven when the in-window pixel bit is 0.
- BG_COLOR, 12'h00F: RGB driven for active video outside the window.

Ports:
- clk  in  1  system clock; all BRAMs share it.
- reset  in  1  asynchronous, active-high reset.
- pixel_tick  in  1  one-clk pulse per pixel; period >= 2 clk.
- h_count  in  10  current column, 0..799.
- v_count  in  10  current line, 0..524.
- video_on_in  in  1  active-video flag from the timing generator.
- hsync_in  in  1  horizontal sync, active-low.
- vsync_in  in  1  vertical sync, active-low.
- anim_enable  in  1  1 = frame animation runs; 0 = frame_sel frozen.
- pixel_vals  in  NUM_FRAMES  bit k = pixel output of frame BRAM k.
- address  out  14  read address to every frame BRAM.
- read_enable  out  1  read enable to every frame BRAM.
- frame_sel  out  4  index of the frame currently displayed.
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}.
- hsync_out  out  1  hsync aligned with rgb.
- vsync_out  out  1  vsync aligned with rgb.
- video_on_out  out  1  video_on aligned with rgb.

Behaviour:
- Reset values: address=0, read_enable=0, frame_sel=0, rgb=0, hsync_out=1, vsync_out=1, video_on_out=0, hold counter=0, pipeline valid flags=0.
- All registers update only on clk edges where pixel_tick=1, except that reset acts immediately.
- Window test: in_win = video_on_in & (h_count - X_OFFSET) in [0, 128<<SCALE_SHIFT) & (v_count - Y_OFFSET) in [0, 96<<SCALE_SHIFT). Use unsigned compares with an explicit >= offset check; subtraction is never allowed to underflow into a false hit.
- Coordinate and address math:
  - col = (h_count - X_OFFSET) >> SCALE_SHIFT, 7 bits.
  - row = (v_count - Y_OFFSET) >> SCALE_SHIFT, 7 bits, range 0..95.
  - address = row*128 + col = {row, col}.
- Stage 1 (tick n):
  - If in_win: register address = {row, col} and read_enable = 1.
  - Else: read_enable = 0 and address = 0.
  - Register s1_win, s1_von, s1_hs, s1_vs from the inputs.
- The BRAM has 1-clk read latency with no output register, so pixel_vals is valid from the clk after stage 1 and holds for the rest of the pixel period.
- Stage 2 (tick n+1), selecting the value in this order:
  - !s1_von → rgb = 0.
  - s1_win → rgb = pixel_vals[frame_sel] ? FG_COLOR : INK_COLOR.
  - Otherwise → rgb = BG_COLOR.
  - hsync_out, vsync_out and video_on_out take their s1_* values.
- Total latency is 2 pixel_ticks from inputs to rgb/sync outputs; the downstream timing generator must budget for this.
- Animation:
  - A vsync start is a tick where vsync_in=0 and the previous sampled vsync_in was 1 (edge detect register resets to 1).
  - On a vsync start with anim_enable=1 and hold_cnt == FRAME_HOLD-1: set hold_cnt = 0 and frame_sel = (frame_sel == NUM_FRAMES-1) ? 0 : frame_sel+1.
  - On a vsync start with anim_enable=1 otherwise: hold_cnt increments.
  - With anim_enable=0: hold_cnt and frame_sel hold.
  - frame_sel changes only during vertical blanking, so no frame tears mid-image.
- Never out of range: frame_sel >= NUM_FRAMES cannot occur; the frame mux is full-width safe.
- Reset mid-line: outputs go to their reset values immediately. Normal output resumes on the 2nd pixel_tick after reset deasserts, and frame_sel restarts at 0.
- pixel_tick=0: all outputs hold their values.

Test Plan:
- Defaults, h=64, v=48, video_on_in=1, tick → address=0, read_enable=1; 2 ticks later rgb = pixel bit 0 of frame 0 color.
- h=64+4*5+3=87, v=48+4*2+1=57 → address=261 (row 2, col 5); h=575, v=431 → address=12287.
- h=63 or h=576 or v=432 with video_on_in=1 → read_enable=0, address=0, rgb=BG_COLOR 12'h00F after 2 ticks; video_on_in=0 → rgb=0.
- Apply a single-tick hsync_in low pulse → hsync_out low exactly 2 ticks later, for 1 tick.
- FRAME_HOLD=2, NUM_FRAMES=10, 20 vsync pulses with anim_enable=1 → frame_sel steps every 2nd pulse, 9→0 wrap on pulse 20; with anim_enable=0 for 5 pulses → frame_sel and hold_cnt unchanged.
- Assert reset mid-window with frame_sel=7 → all outputs at reset values within the same clk; frame_sel=0; first valid rgb on the 2nd tick after release.
